// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_pkg
// Brief  : Result-select encodings, load funct3 codes and FSM state type
// Rev    : 1.0
// ============================================================================
package wb_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    COMMIT   = 2'd2
  } wb_state_t;

  // Unknown load codes behave as LW, so they need word alignment.
  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic r;
    case (f3)
      F3_LB, F3_LBU: r = 1'b0;
      F3_LH, F3_LHU: r = lo[0];
      F3_LW:         r = (lo != 2'b00);
      default:       r = (lo != 2'b00);
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_stage_load_extend.sv
`default_nettype none
// ============================================================================
// Module : load_extend
// Brief  : Byte/half/word lane select with sign or zero extension for loads
// Rev    : 1.0
// ============================================================================
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic [XLEN-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_mem_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_mem_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_result = i_mem_rdata;
    case (i_funct3)
      F3_LB:   o_result = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_result = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   o_result = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  o_result = {{(XLEN-16){1'b0}}, w_half};
      F3_LW:   o_result = i_mem_rdata;
      default: o_result = i_mem_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module : wb_stage
// Brief  : Writeback stage; result select, load wait/extend, one-cycle commit.
//          Optional operand forwarding enabled by macro WB_FWD_EN.
// Rev    : 1.0
// ============================================================================
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
`ifdef WB_FWD_EN
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rd_addr,
  input  logic            reg_write,
  input  logic [1:0]      wb_sel,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            retire,
  output logic            misaligned,
  output logic            timeout
);

  localparam int c_CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_TO_LAST =
    c_CNT_W'((LOAD_TIMEOUT > 0) ? LOAD_TIMEOUT - 1 : 0);

  wb_state_t           r_state;
  wb_state_t           w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic [4:0]          r_rd_lat;
  logic                r_reg_write;
  logic [2:0]          r_funct3;
  logic [1:0]          r_addr_lo;
  logic [4:0]          r_rf_rd;
  logic [XLEN-1:0]     r_rf_data;
  logic                r_misaligned;
  logic                r_timeout;

  logic                w_xfer;
  logic                w_commit_direct;
  logic                w_load_done;
  logic                w_mis_nxt;
  logic                w_to_nxt;
  logic [XLEN-1:0]     w_sel_data;
  logic [XLEN-1:0]     w_load_data;

  assign in_ready = (r_state == IDLE);
  assign w_xfer   = in_valid && in_ready;

  always_comb begin
    w_sel_data = alu_result;
    case (wb_sel)
      WB_ALU:  w_sel_data = alu_result;
      WB_PC4:  w_sel_data = pc_plus4;
      WB_IMM:  w_sel_data = imm;
      default: w_sel_data = alu_result;
    endcase
  end

  // Extension uses the latched load attributes; the live inputs have moved on.
  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_funct3    (r_funct3),
    .i_addr_lo   (r_addr_lo),
    .i_mem_rdata (mem_rdata),
    .o_result    (w_load_data)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_commit_direct = 1'b0;
    w_load_done     = 1'b0;
    w_mis_nxt       = 1'b0;
    w_to_nxt        = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_xfer) begin
          if (wb_sel != WB_MEM) begin
            w_state_nxt     = COMMIT;
            w_commit_direct = 1'b1;
          end else if (load_misaligned(funct3, addr_lo)) begin
            w_mis_nxt = 1'b1;
          end else begin
            w_state_nxt = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        // Data arriving on the last allowed cycle still wins over the timeout.
        if (mem_rvalid) begin
          w_state_nxt = COMMIT;
          w_load_done = 1'b1;
          w_cnt_nxt   = '0;
        end else if ((LOAD_TIMEOUT != 0) && (r_cnt == c_TO_LAST)) begin
          w_state_nxt = IDLE;
          w_to_nxt    = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rd_lat     <= '0;
      r_reg_write  <= 1'b0;
      r_funct3     <= '0;
      r_addr_lo    <= '0;
      r_rf_rd      <= '0;
      r_rf_data    <= '0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_misaligned <= w_mis_nxt;
      r_timeout    <= w_to_nxt;
      if (w_xfer) begin
        r_rd_lat    <= rd_addr;
        r_reg_write <= reg_write;
        r_funct3    <= funct3;
        r_addr_lo   <= addr_lo;
      end
      if (w_commit_direct) begin
        r_rf_rd   <= rd_addr;
        r_rf_data <= w_sel_data;
      end else if (w_load_done) begin
        r_rf_rd   <= r_rd_lat;
        r_rf_data <= w_load_data;
      end
    end
  end

  assign rf_we      = (r_state == COMMIT) && r_reg_write && (r_rf_rd != 5'd0);
  assign rf_rd      = r_rf_rd;
  assign rf_data    = r_rf_data;
  assign retire     = (r_state == COMMIT);
  assign misaligned = r_misaligned;
  assign timeout    = r_timeout;

`ifdef WB_FWD_EN
  assign fwd_data1 = (rf_we && (rf_rd == rs1) && (rs1 != 5'd0)) ? rf_data : rf_rdata1;
  assign fwd_data2 = (rf_we && (rf_rd == rs2) && (rs2 != 5'd0)) ? rf_data : rf_rdata2;
`endif

endmodule
`default_nettype wire
